// File: rtl/alu4_mul_seq.sv
// alu4_mul_seq: unsigned 4x4->8 shift-and-add multiplier that sequences one alu4 held in add mode
// Ports: clk        rising-edge clock
//        reset_n    asynchronous active-low reset
//        start      accept mcand/mplier (honoured in IDLE or DONE)
//        mcand      4-bit unsigned multiplicand
//        mplier     4-bit unsigned multiplier
//        busy       high for the four iteration cycles
//        done       one-cycle pulse, product valid in the same cycle
//        product    8-bit result, held until the next product is formed
module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);
  logic [4:0] add_w, sub_w;
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  always_comb begin
    {c, result} = op == 3'b110 ? add_w :
                  op == 3'b111 ? sub_w :
                  {1'b0, op == 3'b000 ? a & b :
                         op == 3'b001 ? a | b :
                         op == 3'b010 ? a ^ b :
                         op == 3'b011 ? ~a :
                         op == 3'b100 ? {a[2:0], 1'b0} : {1'b0, a[3:1]}};
    n = result[3];
    z = result == 4'h0;
    v = op == 3'b110 ? (a[3] == b[3]) && (result[3] != a[3]) :
        op == 3'b111 ? (a[3] != b[3]) && (result[3] != a[3]) : 1'b0;
  end
endmodule

module alu4_mul_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] mcand,
  input  logic [3:0] mplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] mc_q, mc_d, hi_q, hi_d, lo_q, lo_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  logic [3:0] alu_sum;
  logic       alu_c, unused_n, unused_z, unused_v;
  alu4 u_alu (
    .a(hi_q), .b(mc_q), .op(3'b110),
    .result(alu_sum), .c(alu_c), .n(unused_n), .z(unused_z), .v(unused_v)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mc_q      <= 4'h0;
      hi_q      <= 4'h0;
      lo_q      <= 4'h0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q == EXEC) begin
      // carry-out lands in hi[3]; sum[0] shifts into lo[3]
      {hi_d, lo_d} = lo_q[0] ? {alu_c, alu_sum, lo_q[3:1]} : {1'b0, hi_q, lo_q[3:1]};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        state_d   = DONE;
        product_d = {hi_d, lo_d};
      end
    end else begin
      state_d = start ? EXEC : IDLE;
      if (start) begin
        mc_d  = mcand;
        lo_d  = mplier;
        hi_d  = 4'h0;
        cnt_d = 2'd0;
      end
    end
  end
  assign busy    = state_q == EXEC;
  assign done    = state_q == DONE;
  assign product = product_q;
endmodule

// File: tb/tb_alu4_mul_seq.sv
// tb_alu4_mul_seq: scoreboard bench for alu4_mul_seq with directed vectors and a full operand sweep
module tb_alu4_mul_seq;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mcand = 4'h0;
  logic [3:0] mplier = 4'h0;
  logic       busy, done;
  logic [7:0] product;
  int checks = 0;
  int fails = 0;
  int n_issued = 0;
  int n_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_hold = 8'h00;

  alu4_mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) exp_hold = 8'h00;
    else begin
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done with product %0h expected no done", product);
        end else exp_hold = exp_q.pop_front();
      end
      check(done ? "product_on_done" : "product_held", product, exp_hold);
    end
  end

  // issued at a negedge; returns at the negedge of the DONE cycle so a following call is back-to-back
  task automatic do_op(input logic [3:0] mc, input logic [3:0] mp, input logic [7:0] exp, input bit noise);
    mcand = mc;
    mplier = mp;
    start = 1'b1;
    exp_q.push_back(exp);
    n_issued++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_exec", busy, 1'b1);
      check("done_exec", done, 1'b0);
      start = noise && i < 2;
      if (noise) begin
        mcand = 4'h1;
        mplier = 4'h2;
      end
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end
    do_op(4'd9, 4'd5, 8'd45, 0);
    repeat (3) @(negedge clk);
    check("idle_after_done", done, 1'b0);
    do_op(4'd15, 4'd15, 8'd225, 0);
    @(negedge clk);
    do_op(4'd0, 4'd15, 8'd0, 0);
    @(negedge clk);
    do_op(4'd15, 4'd0, 8'd0, 0);
    @(negedge clk);
    do_op(4'd6, 4'd5, 8'd30, 1);
    do_op(4'd3, 4'd7, 8'd21, 0);
    @(negedge clk);
    mcand = 4'd12;
    mplier = 4'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_product", product, 8'h00);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    do_op(4'd12, 4'd11, 8'd132, 0);
    @(negedge clk);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(4'(a), 4'(b), 8'(a * b), 0);
    repeat (3) @(negedge clk);
    check("pending_expected", exp_q.size(), 0);
    check("done_count", n_done, n_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu4_mul_seq.md
Name: alu4_mul_seq

Overview:
- Multi-cycle controller that sequences one alu4 instance, held in add mode, to form an unsigned 4x4 -> 8-bit product by shift-and-add.
- Accepts operands on a start pulse and iterates four cycles.
- Presents the registered product with a one-cycle done pulse.
- Sits beside the ALU as the first sequenced user of the datapath; later multi-cycle ops reuse the same FSM skeleton.

Parameters:
- none; operand width is fixed at 4 by alu4, iteration count is fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  accept operands; honoured only in IDLE or DONE
- mcand  input  4  multiplicand, unsigned
- mplier  input  4  multiplier, unsigned
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when the product is valid
- product  output  8  registered result, held until the next accepted start

Behaviour:
- Clock and reset: single clock domain. reset_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, product=8'h00. Internal regs cleared: mc_r=0, hi=0, lo=0, cnt=0.
- Internal alu4 connections:
  - a=hi, b=mc_r, op=3'b110 (add) constant.
  - Uses alu4 result (sum) and c (carry-out) only; n, z, v are left unconnected.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - start=1 -> mc_r<=mcand, lo<=mplier, hi<=0, cnt<=0, go to EXEC.
  - Otherwise stay; outputs hold.
- EXEC (exactly 4 cycles, cnt 0..3):
  - If lo[0]=1: {hi,lo} <= {c, sum[3:0], lo[3:1]} (9-bit right shift of carry:sum:lo, dropping lo[0]).
  - If lo[0]=0: {hi,lo} <= {1'b0, hi[3:0], lo[3:1]}.
  - cnt<=cnt+1. When cnt==3, go to DONE after this update.
  - busy=1 throughout EXEC.
  - start is ignored; operands are not re-sampled.
- DONE (one cycle):
  - product <= {hi,lo} captured on entry, so product is valid in the same cycle done=1.
  - done=1, busy=0.
  - start=1 in DONE -> behaves as IDLE accept (back-to-back ops allowed), go to EXEC. Else go to IDLE.
- Timing:
  - Latency: start sampled at edge N -> done high during cycle N+5.
  - Throughput: one product per 5 cycles with back-to-back starts.
- product changes only on entry to DONE. It is stable at all other times, including during the next EXEC.
- Carry handling: the alu4 carry-out must be shifted into hi[3]. Losing it corrupts results with mcand+hi >= 16 (e.g. 15*15).
- Zero operands: no special case. All 4 iterations run and product=0.
- Reset mid-operation: any state returns to IDLE immediately. product clears to 0 and no done pulse is issued.
- Operand inputs are don't-care outside the start-accept cycle.

Test Plan:
- Reset then idle 10 cycles -> busy=0, done=0, product=8'h00 throughout.
- mcand=9, mplier=5, start 1 cycle -> busy high 4 cycles; done pulse at start+5; product=8'd45 (8'h2D) and held afterwards.
- mcand=15, mplier=15 -> product=8'd225 (8'hE1); checks carry shifted into hi. Also mcand=0, mplier=15 -> 0, and mcand=15, mplier=0 -> 0.
- Start pulsed again on cycles 2 and 3 of EXEC with different operands -> ignored; result equals the first op. Then start asserted in the DONE cycle with 3*7 -> second done 5 cycles later, product=8'd21.
- Deassert reset_n asynchronously mid-EXEC (between edges) -> busy, done, product go to 0 immediately. After release, a new 12*11 op -> product=8'd132.
- Exhaustive sweep of all 256 operand pairs, back-to-back -> every product equals mcand*mplier; exactly one done pulse per start.
